// File: rtl/tluh_pkg.sv
// Shared TL-UH constants and atomic function encodings.
package tluh_pkg;

  localparam int unsigned TL_DW            = 32;
  localparam int unsigned TL_SZW           = 3;
  localparam int unsigned TL_AMO_MAX_BEATS = 8;

  // a_param codes for ArithmeticData
  typedef enum logic [2:0] {
    AMO_MIN  = 3'd0,
    AMO_MAX  = 3'd1,
    AMO_MINU = 3'd2,
    AMO_MAXU = 3'd3,
    AMO_ADD  = 3'd4
  } tluh_amo_func_e;

  // a_param codes for LogicalData
  typedef enum logic [2:0] {
    AMO_XOR  = 3'd0,
    AMO_OR   = 3'd1,
    AMO_AND  = 3'd2,
    AMO_SWAP = 3'd3
  } tluh_amo_logic_e;

endpackage

// File: rtl/tluh_amo_sequencer.sv
// Sequences read / ALU / write-back / old-value response for each beat of a
// TL-UH atomic, chaining the ALU carry across beats of a burst.
module tluh_amo_sequencer
  import tluh_pkg::*;
#(
  parameter int unsigned RegAw    = 8,
  parameter int unsigned RegDw    = TL_DW,
  parameter int unsigned MaxBeats = TL_AMO_MAX_BEATS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [RegAw-1:0]      req_addr_i,
  input  logic [TL_SZW-1:0]     req_size_i,
  input  logic                  req_type_i,
  input  logic [2:0]            req_func_i,
  input  logic [RegDw/8-1:0]    req_mask_i,
  input  logic [RegDw-1:0]      req_data_i,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  input  logic [RegDw-1:0]      beat_data_i,
  input  logic [RegDw/8-1:0]    beat_mask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [RegDw-1:0]      rsp_data_o,
  output logic                  rsp_error_o,
  output logic                  rsp_last_o,
  output logic                  re_o,
  output logic                  we_o,
  output logic [RegAw-1:0]      addr_o,
  output logic [RegDw-1:0]      wdata_o,
  output logic [RegDw/8-1:0]    be_o,
  input  logic [RegDw-1:0]      rdata_i,
  input  logic                  error_i,
  output logic                  alu_enable_o,
  output logic [RegDw-1:0]      alu_op1_o,
  output logic [RegDw-1:0]      alu_op2_o,
  output logic                  alu_cin_o,
  output logic                  alu_type_o,
  output logic [2:0]            alu_func_o,
  input  logic [RegDw-1:0]      alu_result_i,
  input  logic                  alu_cout_i
);

  localparam int unsigned RegBw = RegDw / 8;
  localparam int unsigned OffW  = $clog2(RegBw);
  localparam int unsigned BeatW = (1 << TL_SZW) - OffW;

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, WAIT_BEAT} amo_state_t;

  amo_state_t        state;
  logic [RegAw-1:0]  cur_addr;
  logic [RegDw-1:0]  data_q;
  logic [RegDw-1:0]  old_q;
  logic [RegBw-1:0]  mask_q;
  logic              type_q;
  logic [2:0]        func_q;
  logic [BeatW-1:0]  beats_left;
  logic              err_all;
  logic              beat_err;
  logic              carry;

  logic [BeatW-1:0]  req_beats_c;
  logic              req_err_c;
  logic [RegAw-1:0]  req_waddr_c;

  function automatic logic [BeatW-1:0] calc_beats(input logic [TL_SZW-1:0] size);
    if (32'(size) <= OffW) return BeatW'(1);
    return BeatW'(1) << (32'(size) - OffW);
  endfunction

  assign req_beats_c = calc_beats(req_size_i);
  assign req_err_c   = (32'(req_beats_c) > MaxBeats) || (req_addr_i[OffW-1:0] != '0);
  assign req_waddr_c = {req_addr_i[RegAw-1:OffW], OffW'(0)};

  // ALU result is combinational, so write data follows it only while writing
  assign wdata_o = we_o ? alu_result_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cur_addr     <= '0;
      data_q       <= '0;
      old_q        <= '0;
      mask_q       <= '0;
      type_q       <= 1'b0;
      func_q       <= '0;
      beats_left   <= '0;
      err_all      <= 1'b0;
      beat_err     <= 1'b0;
      carry        <= 1'b0;
      req_ready_o  <= 1'b1;
      beat_ready_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_error_o  <= 1'b0;
      rsp_last_o   <= 1'b0;
      re_o         <= 1'b0;
      we_o         <= 1'b0;
      addr_o       <= '0;
      be_o         <= '0;
      alu_enable_o <= 1'b0;
      alu_op1_o    <= '0;
      alu_op2_o    <= '0;
      alu_cin_o    <= 1'b0;
      alu_type_o   <= 1'b0;
      alu_func_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            cur_addr    <= req_waddr_c;
            mask_q      <= req_mask_i;
            data_q      <= req_data_i;
            type_q      <= req_type_i;
            func_q      <= req_func_i;
            beats_left  <= req_beats_c;
            err_all     <= req_err_c;
            carry       <= 1'b0;
            req_ready_o <= 1'b0;
            re_o        <= ~req_err_c;
            addr_o      <= req_waddr_c;
            state       <= READ;
          end
        end
        READ: begin
          old_q        <= err_all ? '1 : rdata_i;
          beat_err     <= error_i | err_all;
          re_o         <= 1'b0;
          we_o         <= ~(error_i | err_all);
          be_o         <= mask_q;
          alu_enable_o <= 1'b1;
          alu_op1_o    <= data_q;
          alu_op2_o    <= err_all ? '1 : rdata_i;
          alu_cin_o    <= carry;
          alu_type_o   <= type_q;
          alu_func_o   <= func_q;
          state        <= WRITE;
        end
        WRITE: begin
          // an errored beat breaks the carry chain
          carry        <= type_q & ~beat_err & alu_cout_i;
          we_o         <= 1'b0;
          be_o         <= '0;
          addr_o       <= '0;
          alu_enable_o <= 1'b0;
          alu_op1_o    <= '0;
          alu_op2_o    <= '0;
          alu_cin_o    <= 1'b0;
          alu_type_o   <= 1'b0;
          alu_func_o   <= '0;
          rsp_valid_o  <= 1'b1;
          rsp_data_o   <= old_q;
          rsp_error_o  <= beat_err;
          rsp_last_o   <= (beats_left == BeatW'(1));
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_error_o <= 1'b0;
            rsp_last_o  <= 1'b0;
            if (rsp_last_o) begin
              req_ready_o <= 1'b1;
              state       <= IDLE;
            end else begin
              beats_left   <= beats_left - BeatW'(1);
              cur_addr     <= cur_addr + RegAw'(RegBw);
              beat_ready_o <= 1'b1;
              state        <= WAIT_BEAT;
            end
          end
        end
        WAIT_BEAT: begin
          if (beat_valid_i) begin
            data_q       <= beat_data_i;
            mask_q       <= beat_mask_i;
            beat_ready_o <= 1'b0;
            re_o         <= ~err_all;
            addr_o       <= cur_addr;
            state        <= READ;
          end
        end
        default: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tluh_amo_sequencer.sv
// Bench for tluh_amo_sequencer: register file and ALU models around the DUT,
// vector table for single-beat atomics plus hand sequences for bursts.
module tb_tluh_amo_sequencer;
  import tluh_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [7:0]  req_addr_i;
  logic [2:0]  req_size_i;
  logic        req_type_i;
  logic [2:0]  req_func_i;
  logic [3:0]  req_mask_i;
  logic [31:0] req_data_i;
  logic        beat_valid_i, beat_ready_o;
  logic [31:0] beat_data_i;
  logic [3:0]  beat_mask_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_error_o, rsp_last_o;
  logic        re_o, we_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [31:0] rdata_i;
  logic        error_i;
  logic        alu_enable_o;
  logic [31:0] alu_op1_o, alu_op2_o;
  logic        alu_cin_o, alu_type_o;
  logic [2:0]  alu_func_o;
  logic [31:0] alu_result_i;
  logic        alu_cout_i;

  always #5 clk = ~clk;

  tluh_amo_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_type_i(req_type_i), .req_func_i(req_func_i),
    .req_mask_i(req_mask_i), .req_data_i(req_data_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .beat_data_i(beat_data_i), .beat_mask_i(beat_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_error_o(rsp_error_o), .rsp_last_o(rsp_last_o),
    .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i), .error_i(error_i),
    .alu_enable_o(alu_enable_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
    .alu_cin_o(alu_cin_o), .alu_type_o(alu_type_o), .alu_func_o(alu_func_o),
    .alu_result_i(alu_result_i), .alu_cout_i(alu_cout_i)
  );

  int checks = 0;
  int failures = 0;

  // register file model
  logic [31:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic        err_en = 1'b0;
  logic [7:0]  err_addr = '0;
  logic        forbid_re = 1'b0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (we_o)
      for (int b = 0; b < 4; b++)
        if (be_o[b]) mem[addr_o[7:2]][8*b +: 8] <= wdata_o[8*b +: 8];
  end
  assign rdata_i = mem[addr_o[7:2]];
  assign error_i = err_en && re_o && (addr_o == err_addr);

  // ALU model
  always_comb begin
    alu_result_i = alu_op2_o;
    alu_cout_i   = 1'b0;
    if (alu_type_o) begin
      case (alu_func_o)
        3'd0: alu_result_i = ($signed(alu_op1_o) < $signed(alu_op2_o)) ? alu_op1_o : alu_op2_o;
        3'd1: alu_result_i = ($signed(alu_op1_o) > $signed(alu_op2_o)) ? alu_op1_o : alu_op2_o;
        3'd2: alu_result_i = (alu_op1_o < alu_op2_o) ? alu_op1_o : alu_op2_o;
        3'd3: alu_result_i = (alu_op1_o > alu_op2_o) ? alu_op1_o : alu_op2_o;
        3'd4: {alu_cout_i, alu_result_i} = 33'(alu_op1_o) + 33'(alu_op2_o) + 33'(alu_cin_o);
        default: alu_result_i = alu_op2_o;
      endcase
    end else begin
      case (alu_func_o)
        3'd0: alu_result_i = alu_op1_o ^ alu_op2_o;
        3'd1: alu_result_i = alu_op1_o | alu_op2_o;
        3'd2: alu_result_i = alu_op1_o & alu_op2_o;
        3'd3: alu_result_i = alu_op1_o;
        default: alu_result_i = alu_op2_o;
      endcase
    end
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        cin;
  } wr_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  wr_t  wq[$];
  rsp_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare writes and response handshakes against queued expectations
  always @(negedge clk) begin
    wr_t  w;
    rsp_t r;
    if (rst_ni === 1'b1) begin
      if (re_o && we_o) begin
        checks++; failures++;
        $display("FAIL re_we_both actual=1 required=0 at %0t", $time);
      end
      if (forbid_re && (re_o || we_o)) begin
        checks++; failures++;
        $display("FAIL no_access actual=re%0b/we%0b required=0 at %0t", re_o, we_o, $time);
      end
      if (we_o) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=addr %02h required=none at %0t", addr_o, $time);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(addr_o), 32'(w.addr));
          chk("wr_data", wdata_o, w.wdata);
          chk("wr_be", 32'(be_o), 32'(w.be));
          chk("wr_cin", 32'(alu_cin_o), 32'(w.cin));
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=%08h required=none at %0t", rsp_data_o, $time);
        end else begin
          r = rq.pop_front();
          chk("rsp_data", rsp_data_o, r.data);
          chk("rsp_error", 32'(rsp_error_o), 32'(r.err));
          chk("rsp_last", 32'(rsp_last_o), 32'(r.last));
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    pre_idx = a[7:2];
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic do_req(input logic [7:0] a, input logic [2:0] sz, input logic t,
                        input logic [2:0] f, input logic [3:0] m, input logic [31:0] d);
    req_addr_i  = a;
    req_size_i  = sz;
    req_type_i  = t;
    req_func_i  = f;
    req_mask_i  = m;
    req_data_i  = d;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] m);
    bit ok = 1'b0;
    beat_data_i  = d;
    beat_mask_i  = m;
    beat_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (beat_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_timeout actual=no beat_ready required=beat_ready");
    end
    @(posedge clk);
    #1 beat_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    chk("sb_drain", 32'(wq.size() + rq.size()), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [2:0]  size;
    logic        typ;
    logic [2:0]  func;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] pre;
    logic        inj;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rsp;
    logic [31:0] exp_mem;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_size_i   = '0;
    req_type_i   = 1'b0;
    req_func_i   = '0;
    req_mask_i   = '0;
    req_data_i   = '0;
    beat_valid_i = 1'b0;
    beat_data_i  = '0;
    beat_mask_i  = '0;
    rsp_ready_i  = 1'b1;

    //             addr   sz    typ   fn    mask   data           pre            inj   we    wdata          rsp            mem            err
    vecs[0]  = '{8'h10, 3'd2, 1'b1, 3'd4, 4'hF, 32'd3,         32'd5,         1'b0, 1'b1, 32'd8,         32'd5,         32'd8,         1'b0};
    vecs[1]  = '{8'h30, 3'd2, 1'b0, 3'd2, 4'h3, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_00F0, 32'hFFFF_FFFF, 32'hFFFF_00F0, 1'b0};
    vecs[2]  = '{8'h40, 3'd2, 1'b0, 3'd0, 4'hF, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'hF00F_F00F, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0};
    vecs[3]  = '{8'h44, 3'd2, 1'b1, 3'd0, 4'hF, 32'd5,         32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0};
    vecs[4]  = '{8'h48, 3'd2, 1'b1, 3'd2, 4'hF, 32'd5,         32'hFFFF_FFFE, 1'b0, 1'b1, 32'd5,         32'hFFFF_FFFE, 32'd5,         1'b0};
    vecs[5]  = '{8'h4C, 3'd2, 1'b0, 3'd3, 4'hF, 32'hCAFE_BABE, 32'h1234_5678, 1'b0, 1'b1, 32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE, 1'b0};
    vecs[6]  = '{8'h50, 3'd0, 1'b1, 3'd4, 4'h1, 32'd2,         32'd1,         1'b0, 1'b1, 32'd3,         32'd1,         32'd3,         1'b0};
    vecs[7]  = '{8'h54, 3'd2, 1'b1, 3'd4, 4'hF, 32'd1,         32'd7,         1'b1, 1'b0, 32'd0,         32'd7,         32'd7,         1'b1};
    vecs[8]  = '{8'h11, 3'd2, 1'b1, 3'd4, 4'hF, 32'd3,         32'h55,        1'b0, 1'b0, 32'd0,         32'hFFFF_FFFF, 32'h55,        1'b1};
    vecs[9]  = '{8'h58, 3'd2, 1'b1, 3'd1, 4'hF, 32'd5,         32'hFFFF_FFFE, 1'b0, 1'b1, 32'd5,         32'hFFFF_FFFE, 32'd5,         1'b0};
    vecs[10] = '{8'h5C, 3'd2, 1'b0, 3'd1, 4'hF, 32'h0000_F000, 32'h0000_0F00, 1'b0, 1'b1, 32'h0000_FF00, 32'h0000_0F00, 32'h0000_FF00, 1'b0};

    // clear register file while in reset
    for (int i = 0; i < 64; i++) preload(8'(i * 4), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_beat_ready", 32'(beat_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_re", 32'(re_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_alu_en", 32'(alu_enable_o), 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);

    // single-beat vector table
    for (int i = 0; i < NV; i++) begin
      preload(vecs[i].addr, vecs[i].pre);
      err_addr  = {vecs[i].addr[7:2], 2'b00};
      err_en    = vecs[i].inj;
      forbid_re = (vecs[i].addr[1:0] != 2'b00);
      if (vecs[i].exp_we)
        wq.push_back('{addr: {vecs[i].addr[7:2], 2'b00}, wdata: vecs[i].exp_wdata,
                       be: vecs[i].mask, cin: 1'b0});
      rq.push_back('{data: vecs[i].exp_rsp, err: vecs[i].exp_err, last: 1'b1});
      do_req(vecs[i].addr, vecs[i].size, vecs[i].typ, vecs[i].func, vecs[i].mask, vecs[i].data);
      @(negedge clk);
      chk("lat_re_c1", 32'(re_o), 32'(!forbid_re));
      chk("lat_busy_c1", 32'(req_ready_o), 32'd0);
      @(negedge clk);
      chk("lat_alu_en_c2", 32'(alu_enable_o), 32'd1);
      @(negedge clk);
      chk("lat_rsp_c3", 32'(rsp_valid_o), 32'd1);
      wait_idle();
      chk("mem_after", mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
      forbid_re = 1'b0;
      err_en    = 1'b0;
    end

    // 2-beat ADD with carry chaining
    preload(8'h20, 32'hFFFF_FFFF);
    preload(8'h24, 32'h0000_0001);
    wq.push_back('{addr: 8'h20, wdata: 32'h0, be: 4'hF, cin: 1'b0});
    wq.push_back('{addr: 8'h24, wdata: 32'h2, be: 4'hF, cin: 1'b1});
    rq.push_back('{data: 32'hFFFF_FFFF, err: 1'b0, last: 1'b0});
    rq.push_back('{data: 32'h0000_0001, err: 1'b0, last: 1'b1});
    do_req(8'h20, 3'd3, 1'b1, 3'd4, 4'hF, 32'd1);
    send_beat(32'd0, 4'hF);
    wait_idle();
    chk("carry_mem1", mem[9], 32'h2);

    // errored first beat must break the carry chain
    preload(8'h70, 32'hFFFF_FFFF);
    preload(8'h74, 32'd5);
    err_addr = 8'h70;
    err_en   = 1'b1;
    wq.push_back('{addr: 8'h74, wdata: 32'd5, be: 4'hF, cin: 1'b0});
    rq.push_back('{data: 32'hFFFF_FFFF, err: 1'b1, last: 1'b0});
    rq.push_back('{data: 32'd5, err: 1'b0, last: 1'b1});
    do_req(8'h70, 3'd3, 1'b1, 3'd4, 4'hF, 32'd1);
    send_beat(32'd0, 4'hF);
    wait_idle();
    err_en = 1'b0;
    chk("errbeat_mem0", mem[28], 32'hFFFF_FFFF);

    // address wrap with response back-pressure
    preload(8'hFC, 32'd10);
    preload(8'h00, 32'd20);
    wq.push_back('{addr: 8'hFC, wdata: 32'd11, be: 4'hF, cin: 1'b0});
    wq.push_back('{addr: 8'h00, wdata: 32'd22, be: 4'hF, cin: 1'b0});
    rq.push_back('{data: 32'd10, err: 1'b0, last: 1'b0});
    rq.push_back('{data: 32'd20, err: 1'b0, last: 1'b1});
    rsp_ready_i = 1'b0;
    do_req(8'hFC, 3'd3, 1'b1, 3'd4, 4'hF, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL bp_rsp_timeout actual=no rsp_valid required=rsp_valid");
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_data", rsp_data_o, 32'd10);
      chk("bp_last", 32'(rsp_last_o), 32'd0);
      chk("bp_no_access", 32'(re_o | we_o), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    send_beat(32'd2, 4'hF);
    wait_idle();
    chk("wrap_mem", mem[0], 32'd22);

    // oversized burst: 16 beats, all errored, no register access
    preload(8'h80, 32'h0000_00AA);
    forbid_re = 1'b1;
    for (int i = 0; i < 16; i++)
      rq.push_back('{data: 32'hFFFF_FFFF, err: 1'b1, last: (i == 15)});
    do_req(8'h80, 3'd6, 1'b1, 3'd4, 4'hF, 32'd1);
    for (int i = 0; i < 15; i++) send_beat(32'd0, 4'hF);
    wait_idle();
    forbid_re = 1'b0;
    chk("oversize_mem", mem[32], 32'h0000_00AA);

    // reset while waiting for the second beat
    preload(8'h60, 32'h100);
    wq.push_back('{addr: 8'h60, wdata: 32'h101, be: 4'hF, cin: 1'b0});
    rq.push_back('{data: 32'h100, err: 1'b0, last: 1'b0});
    do_req(8'h60, 3'd3, 1'b1, 3'd4, 4'hF, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (beat_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL rst_wait_timeout actual=no beat_ready required=beat_ready");
    end
    rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready_o), 32'd1);
    chk("midrst_beat_ready", 32'(beat_ready_o), 32'd0);
    chk("midrst_re", 32'(re_o), 32'd0);
    @(negedge clk);
    chk("midrst_we", 32'(we_o), 32'd0);
    chk("midrst_mem", mem[24], 32'h101);
    chk("midrst_drain", 32'(wq.size() + rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tluh_amo_sequencer.md
Name: tluh_amo_sequencer

Overview:
- Controller that sequences one read-modify-write atomic per TL-UH ArithmeticData/LogicalData request: register read, ALU compute, register write-back, then old-value response. Handles multi-beat bursts.
- Sits between the TL-UH register adapter and the register file.
- Drives the shared ALU instance (op1/op2/cin/type/function) and owns carry chaining across beats.

Parameters:
- RegAw, 8, register address width.
- RegDw, 32, register data width (= tluh_pkg::TL_DW).
- RegBw, RegDw/8, byte lanes (localparam).
- MaxBeats, 8, maximum burst beats accepted; larger requests are errored.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  first beat valid.
- req_ready_o  out  1  sequencer can accept a new atomic.
- req_addr_i  in  RegAw  byte address.
- req_size_i  in  TL_SZW  log2 bytes of the whole atomic.
- req_type_i  in  1  1 = arithmetic, 0 = logical.
- req_func_i  in  3  a_param function code.
- req_mask_i  in  RegBw  byte mask.
- req_data_i  in  RegDw  operand, first beat.
- beat_valid_i  in  1  subsequent beat valid.
- beat_ready_o  out  1  sequencer wants the next beat.
- beat_data_i  in  RegDw  next-beat operand.
- beat_mask_i  in  RegBw  next-beat mask.
- rsp_valid_o  out  1  response beat valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  RegDw  pre-modification register value.
- rsp_error_o  out  1  beat error.
- rsp_last_o  out  1  final beat.
- re_o  out  1  register read enable.
- we_o  out  1  register write enable.
- addr_o  out  RegAw  word-aligned register address.
- wdata_o  out  RegDw  write data.
- be_o  out  RegBw  byte enables.
- rdata_i  in  RegDw  register read data, combinational.
- error_i  in  1  register access error.
- alu_enable_o  out  1  ALU enable.
- alu_op1_o  out  RegDw  ALU operand 1.
- alu_op2_o  out  RegDw  ALU operand 2.
- alu_cin_o  out  1  ALU carry in.
- alu_type_o  out  1  ALU operation type.
- alu_func_o  out  3  ALU function.
- alu_result_i  in  RegDw  ALU result.
- alu_cout_i  in  1  ALU carry out.

Behaviour:
- All registers reset synchronously on clk_i rising edge with rst_ni=0. State=IDLE, carry=0, beats_left=0.
- Outputs in reset and IDLE:
  - req_ready_o=1 in IDLE only, otherwise 0.
  - All other outputs 0.
- Beats:
  - beats = 1 if req_size_i <= log2(RegBw), else 1<<(req_size_i-log2(RegBw)).
  - beats > MaxBeats, or req_addr_i[1:0]!=0, sets err_all.
- States: IDLE -> READ -> WRITE -> RESP -> (WAIT_BEAT -> READ ...) -> IDLE.
- IDLE:
  - On req_valid_i & req_ready_o, latch {addr[RegAw-1:2],2'b00}, mask, data, type, func, beats_left=beats, err_all. Clear carry.
  - Next state READ.
- READ (1 cycle):
  - re_o=~err_all, addr_o=cur_addr.
  - Capture old=rdata_i and beat_err=error_i|err_all.
  - If err_all, old='1.
- WRITE (1 cycle):
  - alu_enable_o=1, op1=latched data, op2=old, cin=carry.
  - we_o=~beat_err, wdata_o=alu_result_i, be_o=mask.
  - carry <= type ? alu_cout_i : 0.
- RESP:
  - rsp_valid_o=1, rsp_data_o=old, rsp_error_o=beat_err, rsp_last_o=(beats_left==1).
  - Hold all response fields stable until rsp_ready_i.
  - On handshake: if last, go IDLE. Otherwise beats_left-1, cur_addr=(cur_addr+RegBw) mod 2^RegAw (wraps at top), go WAIT_BEAT.
- WAIT_BEAT:
  - beat_ready_o=1.
  - On beat_valid_i, latch beat_data_i/beat_mask_i, go READ. Carry is retained.
- Latency: request accepted at cycle 0, READ at cycle 1, WRITE at cycle 2, rsp_valid_o at cycle 3. Minimum 4 cycles per beat including the RESP handshake.
- At most one register access per cycle; re_o and we_o are never both 1.
- beat_valid_i outside WAIT_BEAT and req_valid_i outside IDLE are ignored; upstream holds them.
- Reset mid-operation: return to IDLE next edge. No further re_o/we_o. A write issued before reset stands.
- Error beat: write suppressed, response still returned, sequence continues. carry is reset to 0 after an errored beat.

Decomposition:
- tluh_pkg additions:
  - tluh_amo_func_e: arithmetic MIN=0, MAX=1, MINU=2, MAXU=3, ADD=4; logical XOR=0, OR=1, AND=2, SWAP=3.
  - Constant TL_AMO_MAX_BEATS=8.
- State enum amo_state_t (IDLE, READ, WRITE, RESP, WAIT_BEAT) is local to the module.
- No sub-module: the ALU is instantiated by the parent and wired to the alu_* ports.

Test Plan:
- Single-beat ADD: reg[0x10]=5, data=3, size=2, type=1, func=ADD -> rsp_data_o=5 at cycle 3, we_o at cycle 2 with wdata_o=8, be_o=4'hF, rsp_last_o=1.
- 2-beat ADD with carry: size=3, addr 0x20 holds 0xFFFFFFFF / 0x00000001, operands 1 / 0 -> writes 0x0 then 0x2. Second beat alu_cin_o=1; second access at addr 0x24.
- Logical AND with mask 4'b0011: reg=0xFFFF_FFFF, data=0x0000_00F0 -> wdata_o=0xF0, be_o=4'b0011, rsp_data_o=0xFFFFFFFF.
- Read error: error_i=1 during READ -> we_o stays 0, rsp_error_o=1, return to IDLE after handshake.
- Address wrap and back-pressure: addr=0xFC, size=3 -> second beat addr_o=0x00. rsp_ready_i low for 5 cycles -> rsp fields stable, no new access.
- Misaligned/oversized: addr=0x11 or size giving 16 beats -> no re_o/we_o, every beat rsp_error_o=1 with rsp_data_o='1. Reset asserted during WAIT_BEAT -> IDLE, req_ready_o=1 on the next cycle.
